// File: rtl/nfc_ram_arb_pkg.sv
// Shared widths and ECC read-modify-write state encodings for the page buffer RAM arbiter.
package nfc_ram_arb_pkg;

  localparam int RAM_AW_DEF = 13;
  localparam int RAM_DW_DEF = 16;

  typedef enum logic [1:0] {
    ECC_IDLE = 2'b00,
    ECC_RD   = 2'b01,
    ECC_WR   = 2'b10,
    ECC_ACK  = 2'b11
  } ecc_state_e;

endpackage

// File: rtl/nfc_ram_arb_ecc_rmw.sv
// ECC correction read-modify-write sequencer: RD, WR, then a one-cycle ack.
// Each step waits for ecc_gnt, so a MIF-occupied cycle delays it by one cycle.
module nfc_ecc_rmw
  import nfc_ram_arb_pkg::*;
#(
  parameter int RAM_DW = RAM_DW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ecc_fix_req,
  input  logic [RAM_DW-1:0] ecc_fix_mask,
  input  logic              ecc_gnt,
  input  logic [RAM_DW-1:0] ram_dout,
  output logic              ecc_rd,
  output logic              ecc_wr,
  output logic              ecc_start,
  output logic [RAM_DW-1:0] ecc_wdat,
  output logic              ecc_fix_ack
);

  ecc_state_e        state_q;
  ecc_state_e        state_d;
  logic              ecc_rd_dly;
  logic [RAM_DW-1:0] fix_buf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ECC_IDLE;
      ecc_rd_dly  <= 1'b0;
      fix_buf     <= '0;
      ecc_fix_ack <= 1'b0;
    end else begin
      state_q     <= state_d;
      ecc_rd_dly  <= ecc_rd & ecc_gnt;
      if (ecc_rd_dly) begin
        fix_buf <= ram_dout;
      end
      ecc_fix_ack <= ecc_wr & ecc_gnt;
    end
  end

  always_comb begin
    state_d = state_q;
    ecc_rd  = 1'b0;
    ecc_wr  = 1'b0;
    case (state_q)
      ECC_IDLE: if (ecc_fix_req) state_d = ECC_RD;
      ECC_RD: begin
        ecc_rd = 1'b1;
        if (ecc_gnt) state_d = ECC_WR;
      end
      ECC_WR: begin
        ecc_wr = 1'b1;
        if (ecc_gnt) state_d = ECC_ACK;
      end
      ECC_ACK:  state_d = ECC_IDLE;
      default:  state_d = ECC_IDLE;
    endcase
  end

  // A pending request already outranks the host, before the FSM reaches RD.
  assign ecc_start = (state_q == ECC_IDLE) & ecc_fix_req;

  // Read data is live only in the cycle after the read; a stolen write uses the held copy.
  assign ecc_wdat = (ecc_rd_dly ? ram_dout : fix_buf) ^ ecc_fix_mask;

endmodule

// File: rtl/nfc_ram_arb.sv
// Page buffer RAM arbiter, fixed priority MIF > ECC > host; MIF passes through with zero latency.
// Host acks one cycle after grant; optional host write protection under NFC_RAM_ARB_PROT_EN.
module nfc_ram_arb
  import nfc_ram_arb_pkg::*;
#(
  parameter int RAM_AW = RAM_AW_DEF,
  parameter int RAM_DW = RAM_DW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mif_ram_cen,
  input  logic [1:0]        mif_ram_wen,
  input  logic [RAM_AW-1:0] mif_ram_addr,
  input  logic [RAM_DW-1:0] mif_ram_din,
  output logic [RAM_DW-1:0] mif_ram_dout,
  input  logic              ecc_fix_req,
  input  logic [RAM_AW-1:0] ecc_fix_addr,
  input  logic [RAM_DW-1:0] ecc_fix_mask,
  output logic              ecc_fix_ack,
  input  logic              hst_req,
  input  logic              hst_we,
  input  logic [1:0]        hst_be,
  input  logic [RAM_AW-1:0] hst_addr,
  input  logic [RAM_DW-1:0] hst_wdat,
  output logic [RAM_DW-1:0] hst_rdat,
  output logic              hst_ack,
  output logic              hst_err,
  input  logic              nfc_busy,
  output logic              ram_cen,
  output logic [1:0]        ram_wen,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [RAM_DW-1:0] ram_din,
  input  logic [RAM_DW-1:0] ram_dout
);

  logic              mif_gnt;
  logic              ecc_gnt;
  logic              hst_gnt;
  logic              hst_busy;
  logic              hst_blk;
  logic              ecc_rd;
  logic              ecc_wr;
  logic              ecc_start;
  logic [RAM_DW-1:0] ecc_wdat;

  nfc_ecc_rmw #(
    .RAM_DW (RAM_DW)
  ) u_ecc_rmw (
    .clk          (clk),
    .rst_n        (rst_n),
    .ecc_fix_req  (ecc_fix_req),
    .ecc_fix_mask (ecc_fix_mask),
    .ecc_gnt      (ecc_gnt),
    .ram_dout     (ram_dout),
    .ecc_rd       (ecc_rd),
    .ecc_wr       (ecc_wr),
    .ecc_start    (ecc_start),
    .ecc_wdat     (ecc_wdat),
    .ecc_fix_ack  (ecc_fix_ack)
  );

  assign mif_gnt = !mif_ram_cen;
  assign ecc_gnt = !mif_gnt & (ecc_rd | ecc_wr);
  assign hst_gnt = !mif_gnt & !ecc_gnt & !ecc_start & hst_req & !hst_busy;

`ifdef NFC_RAM_ARB_PROT_EN
  // Blocked writes still take a grant slot so they ack at the normal time.
  assign hst_blk = hst_we & nfc_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hst_err <= 1'b0;
    end else begin
      hst_err <= hst_gnt & hst_blk;
    end
  end
`else
  logic prot_unused;
  assign prot_unused = nfc_busy;
  assign hst_blk     = 1'b0;
  assign hst_err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hst_busy <= 1'b0;
      hst_ack  <= 1'b0;
    end else begin
      hst_ack <= hst_gnt;
      if (hst_gnt) begin
        hst_busy <= 1'b1;
      end else if (hst_ack) begin
        hst_busy <= 1'b0;
      end
    end
  end

  always_comb begin
    ram_cen  = 1'b1;
    ram_wen  = 2'b11;
    ram_addr = '0;
    ram_din  = '0;
    if (mif_gnt) begin
      ram_cen  = mif_ram_cen;
      ram_wen  = mif_ram_wen;
      ram_addr = mif_ram_addr;
      ram_din  = mif_ram_din;
    end else if (ecc_gnt) begin
      ram_cen  = 1'b0;
      ram_addr = ecc_fix_addr;
      if (ecc_wr) begin
        ram_wen = 2'b00;
        ram_din = ecc_wdat;
      end
    end else if (hst_gnt && !hst_blk) begin
      ram_cen  = 1'b0;
      ram_wen  = hst_we ? ~hst_be : 2'b11;
      ram_addr = hst_addr;
      ram_din  = hst_wdat;
    end
  end

  assign mif_ram_dout = ram_dout;
  assign hst_rdat     = ram_dout;

endmodule

// File: tb/tb_nfc_ram_arb.sv
// Directed timing checks plus a randomized MIF/ECC/host mix scored against a golden word array.
module tb_nfc_ram_arb;

  localparam int AW    = 13;
  localparam int DW    = 16;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mif_ram_cen;
  logic [1:0]    mif_ram_wen;
  logic [AW-1:0] mif_ram_addr;
  logic [DW-1:0] mif_ram_din;
  logic [DW-1:0] mif_ram_dout;
  logic          ecc_fix_req;
  logic [AW-1:0] ecc_fix_addr;
  logic [DW-1:0] ecc_fix_mask;
  logic          ecc_fix_ack;
  logic          hst_req;
  logic          hst_we;
  logic [1:0]    hst_be;
  logic [AW-1:0] hst_addr;
  logic [DW-1:0] hst_wdat;
  logic [DW-1:0] hst_rdat;
  logic          hst_ack;
  logic          hst_err;
  logic          nfc_busy;
  logic          ram_cen;
  logic [1:0]    ram_wen;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  always #5 clk = ~clk;

  nfc_ram_arb #(.RAM_AW(AW), .RAM_DW(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mif_ram_cen  (mif_ram_cen),
    .mif_ram_wen  (mif_ram_wen),
    .mif_ram_addr (mif_ram_addr),
    .mif_ram_din  (mif_ram_din),
    .mif_ram_dout (mif_ram_dout),
    .ecc_fix_req  (ecc_fix_req),
    .ecc_fix_addr (ecc_fix_addr),
    .ecc_fix_mask (ecc_fix_mask),
    .ecc_fix_ack  (ecc_fix_ack),
    .hst_req      (hst_req),
    .hst_we       (hst_we),
    .hst_be       (hst_be),
    .hst_addr     (hst_addr),
    .hst_wdat     (hst_wdat),
    .hst_rdat     (hst_rdat),
    .hst_ack      (hst_ack),
    .hst_err      (hst_err),
    .nfc_busy     (nfc_busy),
    .ram_cen      (ram_cen),
    .ram_wen      (ram_wen),
    .ram_addr     (ram_addr),
    .ram_din      (ram_din),
    .ram_dout     (ram_dout)
  );

  // RAM macro model: byte writes, registered read data; backdoor preset and bulk fill.
  logic [DW-1:0] mem  [DEPTH];
  logic [DW-1:0] gold [DEPTH];
  logic [DW-1:0] ram_q = 16'hA5C3;
  logic          bk_we = 1'b0;
  logic          bk_fill = 1'b0;
  logic [AW-1:0] bk_addr = '0;
  logic [DW-1:0] bk_dat = '0;
  logic [31:0]   fill_seed = 32'h1234_5678;

  assign ram_dout = ram_q;

  function automatic logic [DW-1:0] fill_val(input int i, input logic [31:0] s);
    logic [31:0] v;
    v = (32'(i) * 32'd40503) ^ s;
    return v[31:16] ^ v[15:0];
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                          input logic [1:0] be);
    return {be[1] ? new_w[15:8] : old_w[15:8], be[0] ? new_w[7:0] : old_w[7:0]};
  endfunction

  always @(posedge clk) begin
    if (bk_fill) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= fill_val(i, fill_seed);
    end else if (bk_we) begin
      mem[bk_addr] <= bk_dat;
    end else if (!ram_cen) begin
      if (ram_wen == 2'b11) begin
        ram_q <= mem[ram_addr];
      end else begin
        if (!ram_wen[0]) mem[ram_addr][7:0]  <= ram_din[7:0];
        if (!ram_wen[1]) mem[ram_addr][15:8] <= ram_din[15:8];
      end
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic preset(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bk_we   = 1'b1;
    bk_addr = a;
    bk_dat  = d;
    step();
    bk_we   = 1'b0;
  endtask

  bit            ecc_drop;
  bit            hst_drop;
  bit            mif_rd_prev;
  bit            seen;
  logic          err_exp;
  logic [DW-1:0] mif_exp;
  int            ecc_done;
  int            hst_done;
  int            bad;

  initial begin
    rst_n = 1'b0;
    mif_ram_cen = 1'b1; mif_ram_wen = 2'b11; mif_ram_addr = '0; mif_ram_din = '0;
    ecc_fix_req = 1'b0; ecc_fix_addr = '0; ecc_fix_mask = '0;
    hst_req = 1'b0; hst_we = 1'b0; hst_be = 2'b00; hst_addr = '0; hst_wdat = '0;
    nfc_busy = 1'b0;
    bk_fill = 1'b1;
    step();
    bk_fill = 1'b0;

    // Reset state
    mid();
    chk("rst_ram_cen",  32'(ram_cen), 32'd1);
    chk("rst_ram_wen",  32'(ram_wen), 32'd3);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_din",  32'(ram_din), 32'd0);
    chk("rst_acks",     32'({ecc_fix_ack, hst_ack, hst_err}), 32'd0);
    chk("rst_mif_dout", 32'(mif_ram_dout), 32'hA5C3);
    chk("rst_hst_rdat", 32'(hst_rdat), 32'hA5C3);
    step();
    rst_n = 1'b1;
    step();

    // ECC fix, no MIF
    preset(13'h100, 16'h5A3C);
    ecc_fix_req = 1'b1; ecc_fix_addr = 13'h100; ecc_fix_mask = 16'h0004;
    mid(); chk("ecc1_req_idle_cen", 32'(ram_cen), 32'd1); step();
    mid(); chk("ecc1_rd", 32'({ram_cen, ram_wen, ram_addr}), 32'({1'b0, 2'b11, 13'h100})); step();
    mid(); chk("ecc1_wr", 32'({ram_cen, ram_wen, ram_din}), 32'({1'b0, 2'b00, 16'h5A38}));
    chk("ecc1_no_early_ack", 32'(ecc_fix_ack), 32'd0); step();
    mid(); chk("ecc1_ack", 32'({ecc_fix_ack, ram_cen}), 32'd3); step();
    ecc_fix_req = 1'b0;
    chk("ecc1_mem", 32'(mem[13'h100]), 32'h5A38);

    // ECC fix with a MIF read burst stealing cycles 1-4
    for (int k = 0; k < 4; k++) preset(AW'(13'h1000 + k), DW'(16'hC000 + k));
    preset(13'h100, 16'h5A3C);
    ecc_fix_req = 1'b1;
    mid(); step();
    mid(); chk("ecc2_rd_addr", 32'(ram_addr), 32'h100); step();
    for (int k = 0; k < 4; k++) begin
      mif_ram_cen = 1'b0; mif_ram_wen = 2'b11; mif_ram_addr = AW'(13'h1000 + k);
      mid();
      chk("ecc2_mif_pass", 32'({ram_cen, ram_wen, ram_addr}), 32'({1'b0, 2'b11, AW'(13'h1000 + k)}));
      if (k > 0) chk("ecc2_mif_dout", 32'(mif_ram_dout), 32'(16'hC000 + k - 1));
      step();
    end
    mif_ram_cen = 1'b1;
    mid();
    chk("ecc2_mif_dout_last", 32'(mif_ram_dout), 32'hC003);
    chk("ecc2_wr_held", 32'({ram_cen, ram_wen, ram_addr, ram_din}), {1'b0, 2'b00, 13'h100, 16'h5A38});
    step();
    mid(); chk("ecc2_ack", 32'(ecc_fix_ack), 32'd1); step();
    ecc_fix_req = 1'b0;
    chk("ecc2_mem", 32'(mem[13'h100]), 32'h5A38);

    // Host partial write then readback
    preset(13'h200, 16'hFFFF);
    hst_req = 1'b1; hst_we = 1'b1; hst_be = 2'b01; hst_addr = 13'h200; hst_wdat = 16'h1234;
    mid(); chk("hst_wr_gnt", 32'({ram_cen, ram_wen, ram_addr, ram_din}), {1'b0, 2'b10, 13'h200, 16'h1234});
    chk("hst_wr_no_early_ack", 32'(hst_ack), 32'd0); step();
    mid(); chk("hst_wr_ack", 32'({hst_ack, hst_err}), 32'd2); step();
    hst_req = 1'b0;
    mid(); chk("hst_ack_single", 32'(hst_ack), 32'd0); step();
    chk("hst_wr_mem", 32'(mem[13'h200]), 32'hFF34);
    hst_req = 1'b1; hst_we = 1'b0;
    mid(); chk("hst_rd_gnt", 32'({ram_cen, ram_wen}), 32'd3); step();
    mid(); chk("hst_rd_ack", 32'(hst_ack), 32'd1); chk("hst_rd_data", 32'(hst_rdat), 32'hFF34); step();
    hst_req = 1'b0;

    // ECC and host read requested together
    preset(13'h300, 16'h0F0F);
    ecc_fix_req = 1'b1; ecc_fix_addr = 13'h300; ecc_fix_mask = 16'h0100;
    hst_req = 1'b1; hst_we = 1'b0; hst_addr = 13'h200;
    mid(); chk("both_req_cycle", 32'(ram_cen), 32'd1); step();
    mid(); chk("both_ecc_rd", 32'({ram_cen, ram_wen, ram_addr}), 32'({1'b0, 2'b11, 13'h300})); step();
    mid(); chk("both_ecc_wr", 32'({ram_cen, ram_wen, ram_din}), 32'({1'b0, 2'b00, 16'h0E0F})); step();
    mid(); chk("both_ecc_ack", 32'(ecc_fix_ack), 32'd1);
    chk("both_hst_gnt", 32'({ram_cen, ram_wen, ram_addr}), 32'({1'b0, 2'b11, 13'h200}));
    chk("both_hst_no_ack", 32'(hst_ack), 32'd0); step();
    ecc_fix_req = 1'b0;
    mid(); chk("both_hst_ack_c3", 32'(hst_ack), 32'd1); chk("both_hst_rdat", 32'(hst_rdat), 32'hFF34); step();
    hst_req = 1'b0;

    // Reset while the FSM is in WR
    preset(13'h400, 16'hABCD);
    ecc_fix_req = 1'b1; ecc_fix_addr = 13'h400; ecc_fix_mask = 16'h00F0;
    mid(); step();
    mid(); step();
    mid(); chk("rst_rmw_in_wr", 32'(ram_wen), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_rmw_cen", 32'(ram_cen), 32'd1);
    ecc_fix_req = 1'b0;
    step();
    mid(); chk("rst_rmw_hold", 32'({ram_cen, ecc_fix_ack}), 32'd2); step();
    rst_n = 1'b1;
    step();
    chk("rst_rmw_mem", 32'(mem[13'h400]), 32'hABCD);
    ecc_fix_req = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      mid();
      if (ecc_fix_ack) seen = 1'b1;
      step();
    end
    ecc_fix_req = 1'b0;
    chk("rst_reissue_ack", 32'(seen), 32'd1);
    chk("rst_reissue_mem", 32'(mem[13'h400]), 32'hAB3D);

    // Host write while NAND transfer active
    preset(13'h010, 16'h1111);
    nfc_busy = 1'b1;
    hst_req = 1'b1; hst_we = 1'b1; hst_be = 2'b11; hst_addr = 13'h010; hst_wdat = 16'h2222;
`ifdef NFC_RAM_ARB_PROT_EN
    mid(); chk("prot_no_cen", 32'(ram_cen), 32'd1); step();
    mid(); chk("prot_ack_err", 32'({hst_ack, hst_err}), 32'd3); step();
    hst_req = 1'b0;
    chk("prot_mem", 32'(mem[13'h010]), 32'h1111);
`else
    mid(); chk("noprot_cen", 32'({ram_cen, ram_wen}), 32'd0); step();
    mid(); chk("noprot_ack_err", 32'({hst_ack, hst_err}), 32'd2); step();
    hst_req = 1'b0;
    chk("noprot_mem", 32'(mem[13'h010]), 32'h2222);
`endif
    step();
    hst_req = 1'b1; hst_we = 1'b0;
    mid(); step();
    mid(); chk("busy_rd_ack", 32'({hst_ack, hst_err}), 32'd2);
`ifdef NFC_RAM_ARB_PROT_EN
    chk("busy_rd_data", 32'(hst_rdat), 32'h1111);
`else
    chk("busy_rd_data", 32'(hst_rdat), 32'h2222);
`endif
    step();
    hst_req = 1'b0; nfc_busy = 1'b0;

    // Randomized mix: MIF in the upper half, ECC and host in the lower half
    fill_seed = $urandom;
    bk_fill = 1'b1;
    step();
    bk_fill = 1'b0;
    for (int i = 0; i < DEPTH; i++) gold[i] = fill_val(i, fill_seed);
    ecc_drop = 1'b0; hst_drop = 1'b0; mif_rd_prev = 1'b0;
    ecc_done = 0; hst_done = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (ecc_drop) begin ecc_fix_req = 1'b0; ecc_drop = 1'b0; end
      if (hst_drop) begin hst_req = 1'b0; hst_drop = 1'b0; end
      if (cyc >= 3002 && !ecc_fix_req && !hst_req) break;
      if (cyc < 3000 && $urandom_range(0, 1) == 1) begin
        mif_ram_cen  = 1'b0;
        mif_ram_addr = 13'h1000 | AW'($urandom_range(0, 4095));
        mif_ram_wen  = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'($urandom_range(0, 2));
        mif_ram_din  = DW'($urandom);
      end else begin
        mif_ram_cen  = 1'b1;
      end
      if (cyc < 3000 && !ecc_fix_req && $urandom_range(0, 11) == 0) begin
        ecc_fix_req  = 1'b1;
        ecc_fix_addr = AW'($urandom_range(0, 4095));
        ecc_fix_mask = DW'($urandom_range(1, 65535));
      end
      if (cyc < 3000 && !hst_req && $urandom_range(0, 5) == 0) begin
        nfc_busy = 1'($urandom_range(0, 1));
        hst_req  = 1'b1;
        hst_we   = 1'($urandom_range(0, 1));
        hst_be   = 2'($urandom_range(0, 3));
        hst_addr = AW'($urandom_range(0, 4095));
        hst_wdat = DW'($urandom);
      end
      mid();
      if (mif_rd_prev) chk("rnd_mif_rdat", 32'(mif_ram_dout), 32'(mif_exp));
      mif_rd_prev = 1'b0;
      if (!mif_ram_cen) begin
        chk("rnd_mif_pass", {ram_cen, ram_wen, ram_addr, ram_din},
            {1'b0, mif_ram_wen, mif_ram_addr, mif_ram_din});
        if (mif_ram_wen == 2'b11) begin
          mif_exp = gold[mif_ram_addr];
          mif_rd_prev = 1'b1;
        end else begin
          gold[mif_ram_addr] = merge(gold[mif_ram_addr], mif_ram_din, ~mif_ram_wen);
        end
      end
      if (ecc_fix_ack) begin
        chk("rnd_ecc_ack_req", 32'(ecc_fix_req), 32'd1);
        gold[ecc_fix_addr] = gold[ecc_fix_addr] ^ ecc_fix_mask;
        ecc_done++;
        ecc_drop = 1'b1;
      end
      if (hst_ack) begin
        chk("rnd_hst_ack_req", 32'(hst_req), 32'd1);
`ifdef NFC_RAM_ARB_PROT_EN
        err_exp = hst_we & nfc_busy;
`else
        err_exp = 1'b0;
`endif
        chk("rnd_hst_err", 32'(hst_err), 32'(err_exp));
        if (!hst_we) chk("rnd_hst_rdat", 32'(hst_rdat), 32'(gold[hst_addr]));
        else if (!err_exp) gold[hst_addr] = merge(gold[hst_addr], hst_wdat, hst_be);
        hst_done++;
        hst_drop = 1'b1;
      end
      step();
    end
    mif_ram_cen = 1'b1;
    chk("rnd_drain", 32'({ecc_fix_req, hst_req}), 32'd0);
    chk("rnd_ecc_activity", 32'(ecc_done > 20), 32'd1);
    chk("rnd_hst_activity", 32'(hst_done > 50), 32'd1);
    step();
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== gold[i]) bad++;
    chk("rnd_mem_final", 32'(bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
